// File: rtl/tl_mem_a_arbiter.sv
// TileLink-UL A/D channel arbiter sharing one memory port between CORES L1 masters.
// Define TL_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins) instead of round-robin.
module tl_mem_a_arbiter #(
   parameter int CORES     = 4,
   parameter int ADDR_W    = 64,
   parameter int DATA_W    = 64,
   parameter int SRC_W     = 2,
   parameter int MAX_OUTST = 4
) (
   input  logic                               clk_i,
   input  logic                               rst_ni,
   input  logic [CORES*3-1:0]                 up_a_opcode_i,
   input  logic [CORES*3-1:0]                 up_a_param_i,
   input  logic [CORES*3-1:0]                 up_a_size_i,
   input  logic [CORES*SRC_W-1:0]             up_a_source_i,
   input  logic [CORES*ADDR_W-1:0]            up_a_address_i,
   input  logic [CORES*(DATA_W/8)-1:0]        up_a_mask_i,
   input  logic [CORES*DATA_W-1:0]            up_a_data_i,
   input  logic [CORES-1:0]                   up_a_valid_i,
   output logic [CORES-1:0]                   up_a_ready_o,
   output logic [2:0]                         up_d_opcode_o,
   output logic [1:0]                         up_d_param_o,
   output logic [2:0]                         up_d_size_o,
   output logic [1:0]                         up_d_sink_o,
   output logic                               up_d_denied_o,
   output logic [DATA_W-1:0]                  up_d_data_o,
   output logic                               up_d_corrupt_o,
   output logic [SRC_W-1:0]                   up_d_source_o,
   output logic [CORES-1:0]                   up_d_valid_o,
   input  logic [CORES-1:0]                   up_d_ready_i,
   output logic [2:0]                         mem_a_opcode_o,
   output logic [2:0]                         mem_a_param_o,
   output logic [2:0]                         mem_a_size_o,
   output logic [ADDR_W-1:0]                  mem_a_address_o,
   output logic [DATA_W/8-1:0]                mem_a_mask_o,
   output logic [DATA_W-1:0]                  mem_a_data_o,
   output logic [SRC_W+$clog2(CORES)-1:0]     mem_a_source_o,
   output logic                               mem_a_valid_o,
   input  logic                               mem_a_ready_i,
   input  logic [2:0]                         mem_d_opcode_i,
   input  logic [1:0]                         mem_d_param_i,
   input  logic [2:0]                         mem_d_size_i,
   input  logic [SRC_W+$clog2(CORES)-1:0]     mem_d_source_i,
   input  logic [1:0]                         mem_d_sink_i,
   input  logic                               mem_d_denied_i,
   input  logic [DATA_W-1:0]                  mem_d_data_i,
   input  logic                               mem_d_corrupt_i,
   input  logic                               mem_d_valid_i,
   output logic                               mem_d_ready_o,
   output logic                               route_err_o
);

   localparam int IDX_W = $clog2(CORES);
   localparam int SW    = SRC_W + IDX_W;
   localparam int MW    = DATA_W / 8;

   logic             lock_vld;
   logic [IDX_W-1:0] lock_idx;
   logic [3:0]       outst [CORES];
   logic             route_err;

   logic [CORES-1:0] elig;
   logic [CORES-1:0] a_inc;
   logic [CORES-1:0] d_dec;
   logic [IDX_W-1:0] sel;
   logic             sel_vld;
   logic             a_hs;
   logic [IDX_W-1:0] d_idx;
   logic             d_ok;
   logic             d_hs;
   logic             d_zero;
   int               scan_base;

`ifdef TL_ARB_FIXED_PRIO_EN
   assign scan_base = 0;
`else
   logic [IDX_W-1:0] rr_ptr;
   assign scan_base = int'(rr_ptr);
`endif

   always_comb begin
      for (int c = 0; c < CORES; c++) begin
         elig[c] = up_a_valid_i[c] && (outst[c] < 4'(MAX_OUTST));
      end
   end

   // A held request keeps its grant until it handshakes
   always_comb begin
      sel     = '0;
      sel_vld = 1'b0;
      if (lock_vld) begin
         sel     = lock_idx;
         sel_vld = 1'b1;
      end else begin
         for (int i = 0; i < CORES; i++) begin
            if (!sel_vld && elig[(scan_base + i) % CORES]) begin
               sel     = IDX_W'((scan_base + i) % CORES);
               sel_vld = 1'b1;
            end
         end
      end
   end

   assign a_hs            = sel_vld && mem_a_ready_i;
   assign mem_a_valid_o   = sel_vld;
   assign mem_a_opcode_o  = up_a_opcode_i[int'(sel)*3 +: 3];
   assign mem_a_param_o   = up_a_param_i[int'(sel)*3 +: 3];
   assign mem_a_size_o    = up_a_size_i[int'(sel)*3 +: 3];
   assign mem_a_address_o = up_a_address_i[int'(sel)*ADDR_W +: ADDR_W];
   assign mem_a_mask_o    = up_a_mask_i[int'(sel)*MW +: MW];
   assign mem_a_data_o    = up_a_data_i[int'(sel)*DATA_W +: DATA_W];
   assign mem_a_source_o  = {sel, up_a_source_i[int'(sel)*SRC_W +: SRC_W]};

   always_comb begin
      up_a_ready_o = '0;
      if (a_hs) begin
         up_a_ready_o[sel] = 1'b1;
      end
   end

   assign d_idx  = mem_d_source_i[SW-1:SRC_W];
   assign d_ok   = int'(d_idx) < CORES;
   assign d_zero = outst[d_idx] == 4'd0;

   assign mem_d_ready_o = d_ok ? up_d_ready_i[d_idx] : 1'b1;
   assign d_hs          = mem_d_valid_i && mem_d_ready_o;

   always_comb begin
      for (int c = 0; c < CORES; c++) begin
         up_d_valid_o[c] = mem_d_valid_i && d_ok && (d_idx == IDX_W'(c));
      end
   end

   assign up_d_opcode_o  = mem_d_opcode_i;
   assign up_d_param_o   = mem_d_param_i;
   assign up_d_size_o    = mem_d_size_i;
   assign up_d_sink_o    = mem_d_sink_i;
   assign up_d_denied_o  = mem_d_denied_i;
   assign up_d_data_o    = mem_d_data_i;
   assign up_d_corrupt_o = mem_d_corrupt_i;
   assign up_d_source_o  = mem_d_source_i[SRC_W-1:0];
   assign route_err_o    = route_err;

   // Decrements on an empty counter are suppressed and flagged instead
   always_comb begin
      for (int c = 0; c < CORES; c++) begin
         a_inc[c] = a_hs && (sel == IDX_W'(c));
         d_dec[c] = d_hs && d_ok && (d_idx == IDX_W'(c)) && (outst[c] != 4'd0);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         lock_vld  <= 1'b0;
         lock_idx  <= '0;
         route_err <= 1'b0;
`ifndef TL_ARB_FIXED_PRIO_EN
         rr_ptr    <= '0;
`endif
         for (int c = 0; c < CORES; c++) begin
            outst[c] <= 4'd0;
         end
      end else begin
         if (a_hs) begin
            lock_vld <= 1'b0;
`ifndef TL_ARB_FIXED_PRIO_EN
            rr_ptr   <= (sel == IDX_W'(CORES - 1)) ? '0 : sel + 1'b1;
`endif
         end else if (sel_vld) begin
            lock_vld <= 1'b1;
            lock_idx <= sel;
         end
         if (d_hs && (!d_ok || d_zero)) begin
            route_err <= 1'b1;
         end
         for (int c = 0; c < CORES; c++) begin
            if (a_inc[c] && !d_dec[c] && outst[c] < 4'(MAX_OUTST)) begin
               outst[c] <= outst[c] + 4'd1;
            end else if (d_dec[c] && !a_inc[c]) begin
               outst[c] <= outst[c] - 4'd1;
            end
         end
      end
   end

endmodule
